// File: rtl/fetch_stage_if.sv
// fetch_stage_if: instruction-memory, hazard-control, redirect and IF/ID signals of the fetch stage.
// Carries fetch_halted only when FETCH_HALT_EN is defined.
interface fetch_stage_if;
   logic        ihit;
   logic [31:0] imemload;
   logic        imemREN;
   logic [31:0] imemaddr;
   logic        stall_PC;
   logic        stall_IFID;
   logic        flush_IFID;
   logic        redirect_en;
   logic [31:0] redirect_pc;
   logic        ifid_valid;
   logic [31:0] ifid_instr;
   logic [31:0] ifid_pc;
   logic [31:0] ifid_npc;
`ifdef FETCH_HALT_EN
   logic        fetch_halted;
`endif
   modport master (
      input  ihit, imemload, stall_PC, stall_IFID, flush_IFID, redirect_en, redirect_pc,
`ifdef FETCH_HALT_EN
      output fetch_halted,
`endif
      output imemREN, imemaddr, ifid_valid, ifid_instr, ifid_pc, ifid_npc
   );
   modport slave (
      output ihit, imemload, stall_PC, stall_IFID, flush_IFID, redirect_en, redirect_pc,
`ifdef FETCH_HALT_EN
      input  fetch_halted,
`endif
      input  imemREN, imemaddr, ifid_valid, ifid_instr, ifid_pc, ifid_npc
   );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: PC register, instruction fetch and IF/ID register with redirect deferral across cache misses.
// Define FETCH_HALT_EN to stop fetching after an opcode 6'b111111 instruction enters IF/ID.
module fetch_stage #(
   parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
   input  logic          CLK,
   input  logic          nRST,
   fetch_stage_if.master bus
);
   typedef enum logic {FETCH, REDIR} state_e;
   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d, pend_q, pend_d;
   logic [31:0] instr_q, instr_d, ipc_q, ipc_d, npc_q, npc_d;
   logic        valid_q, valid_d;
   logic        halted_q, load, hold, take;
   logic [31:0] rpc;
   assign rpc  = {bus.redirect_pc[31:2], 2'b00};
   assign load = (state_q == FETCH) & bus.ihit & ~bus.redirect_en & ~halted_q;
   assign hold = ~bus.flush_IFID & bus.stall_IFID;
   assign take = ~bus.flush_IFID & ~bus.stall_IFID & load;
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      pend_d  = pend_q;
      if (state_q == FETCH) begin
         // a miss keeps PC steady so the outstanding request is not disturbed
         if (bus.redirect_en & (bus.ihit | halted_q)) pc_d = rpc;
         else if (bus.redirect_en) begin
            pend_d  = rpc;
            state_d = REDIR;
         end else if (~bus.stall_PC & bus.ihit & ~halted_q) pc_d = pc_q + 32'd4;
      end else begin
         if (bus.redirect_en) pend_d = rpc;
         if (bus.ihit) begin
            pc_d    = bus.redirect_en ? rpc : pend_q;
            state_d = FETCH;
         end
      end
      valid_d = hold ? valid_q : take;
      instr_d = hold ? instr_q : take ? bus.imemload : '0;
      ipc_d   = hold ? ipc_q : take ? pc_q : '0;
      npc_d   = hold ? npc_q : take ? pc_q + 32'd4 : '0;
   end
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q <= FETCH;
         pc_q    <= PC_INIT;
         pend_q  <= '0;
         valid_q <= 1'b0;
         instr_q <= '0;
         ipc_q   <= '0;
         npc_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         pend_q  <= pend_d;
         valid_q <= valid_d;
         instr_q <= instr_d;
         ipc_q   <= ipc_d;
         npc_q   <= npc_d;
      end
   end
`ifdef FETCH_HALT_EN
   logic halted_d;
   // a redirect means the HALT was on the wrong path
   assign halted_d = bus.redirect_en ? 1'b0 : halted_q | (take & (bus.imemload[31:26] == 6'h3F));
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) halted_q <= 1'b0;
      else       halted_q <= halted_d;
   end
   assign bus.fetch_halted = halted_q;
`else
   assign halted_q = 1'b0;
`endif
   assign bus.imemREN    = ~halted_q;
   assign bus.imemaddr   = pc_q;
   assign bus.ifid_valid = valid_q;
   assign bus.ifid_instr = instr_q;
   assign bus.ifid_pc    = ipc_q;
   assign bus.ifid_npc   = npc_q;
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: scoreboard bench for fetch_stage; expected IF/ID contents are queued as each cycle is driven.
module tb_fetch_stage;
   typedef struct packed {
      logic        v;
      logic [31:0] i, p, n;
   } ifid_t;
   typedef struct packed {
      logic        h;
      logic [31:0] w;
      logic        sp, si, fl, re;
      logic [31:0] rp;
      ifid_t       e;
      logic [31:0] a;
   } step_t;
   localparam ifid_t BUB = '0;
   logic  clk = 1'b0;
   logic  nrst = 1'b0;
   int    vectors = 0;
   int    errs = 0;
   ifid_t exp_q[$];
   fetch_stage_if bus();
   fetch_stage #(.PC_INIT(32'h100)) dut (.CLK(clk), .nRST(nrst), .bus(bus.master));
   always #5 clk = ~clk;
   function automatic ifid_t ifid_now();
      return {bus.ifid_valid, bus.ifid_instr, bus.ifid_pc, bus.ifid_npc};
   endfunction
   task automatic drive(input step_t s);
      bus.ihit = s.h;
      bus.imemload = s.w;
      bus.stall_PC = s.sp;
      bus.stall_IFID = s.si;
      bus.flush_IFID = s.fl;
      bus.redirect_en = s.re;
      bus.redirect_pc = s.rp;
      exp_q.push_back(s.e);
      @(posedge clk);
      #1;
   endtask
   task automatic idle();
      bus.ihit = 1'b0; bus.imemload = '0; bus.stall_PC = 1'b0; bus.stall_IFID = 1'b0;
      bus.flush_IFID = 1'b0; bus.redirect_en = 1'b0; bus.redirect_pc = '0;
   endtask
   task automatic test_reset();
      idle();
      nrst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      vectors++; if (ifid_now() !== BUB) begin errs++; $display("FAIL reset ifid got %h exp %h", ifid_now(), BUB); end
      vectors++; if (bus.imemaddr !== 32'h100) begin errs++; $display("FAIL reset imemaddr got %h exp 100", bus.imemaddr); end
      vectors++; if (bus.imemREN !== 1'b1) begin errs++; $display("FAIL reset imemREN got %b exp 1", bus.imemREN); end
      nrst = 1'b1;
   endtask
   task automatic test_sequential();
      step_t s[3] = '{
         '{1'b1, 32'hA000_000A, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, '{1'b1, 32'hA000_000A, 32'h100, 32'h104}, 32'h104},
         '{1'b1, 32'hB000_000B, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, '{1'b1, 32'hB000_000B, 32'h104, 32'h108}, 32'h108},
         '{1'b1, 32'hC000_000C, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, '{1'b1, 32'hC000_000C, 32'h108, 32'h10C}, 32'h10C}};
      ifid_t e;
      foreach (s[k]) begin
         drive(s[k]); e = exp_q.pop_front();
         vectors++; if (ifid_now() !== e) begin errs++; $display("FAIL seq[%0d] ifid got %h exp %h", k, ifid_now(), e); end
         vectors++; if (bus.imemaddr !== s[k].a) begin errs++; $display("FAIL seq[%0d] imemaddr got %h exp %h", k, bus.imemaddr, s[k].a); end
      end
   endtask
   task automatic test_stall();
      step_t s[5] = '{
         '{1'b1, 32'h0,         1'b0, 1'b0, 1'b0, 1'b1, 32'h1FC, BUB, 32'h1FC},
         '{1'b1, 32'h1111_1111, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, '{1'b1, 32'h1111_1111, 32'h1FC, 32'h200}, 32'h200},
         '{1'b1, 32'h2222_2222, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, '{1'b1, 32'h1111_1111, 32'h1FC, 32'h200}, 32'h200},
         '{1'b1, 32'h2222_2222, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, '{1'b1, 32'h1111_1111, 32'h1FC, 32'h200}, 32'h200},
         '{1'b1, 32'h2222_2222, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, '{1'b1, 32'h2222_2222, 32'h200, 32'h204}, 32'h204}};
      ifid_t e;
      foreach (s[k]) begin
         drive(s[k]); e = exp_q.pop_front();
         vectors++; if (ifid_now() !== e) begin errs++; $display("FAIL stall[%0d] ifid got %h exp %h", k, ifid_now(), e); end
         vectors++; if (bus.imemaddr !== s[k].a) begin errs++; $display("FAIL stall[%0d] imemaddr got %h exp %h", k, bus.imemaddr, s[k].a); end
      end
   endtask
   task automatic test_miss_redirect();
      step_t s[7] = '{
         '{1'b1, 32'h0,         1'b0, 1'b0, 1'b0, 1'b1, 32'h300, BUB, 32'h300},
         '{1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   BUB, 32'h300},
         '{1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b1, 32'h80,  BUB, 32'h300},
         '{1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   BUB, 32'h300},
         '{1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   BUB, 32'h300},
         '{1'b1, 32'h3333_3333, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   BUB, 32'h80},
         '{1'b1, 32'h4444_4444, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, '{1'b1, 32'h4444_4444, 32'h80, 32'h84}, 32'h84}};
      ifid_t e;
      foreach (s[k]) begin
         drive(s[k]); e = exp_q.pop_front();
         vectors++; if (ifid_now() !== e) begin errs++; $display("FAIL miss[%0d] ifid got %h exp %h", k, ifid_now(), e); end
         vectors++; if (bus.imemaddr !== s[k].a) begin errs++; $display("FAIL miss[%0d] imemaddr got %h exp %h", k, bus.imemaddr, s[k].a); end
      end
   endtask
   task automatic test_back_to_back_redirect();
      step_t s[5] = '{
         '{1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b1, 32'h80,  BUB, 32'h84},
         '{1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b1, 32'hC0,  BUB, 32'h84},
         '{1'b1, 32'h5555_5555, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   BUB, 32'hC0},
         '{1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b1, 32'h500, BUB, 32'hC0},
         '{1'b1, 32'h6666_6666, 1'b0, 1'b0, 1'b0, 1'b1, 32'h603, BUB, 32'h600}};
      ifid_t e;
      foreach (s[k]) begin
         drive(s[k]); e = exp_q.pop_front();
         vectors++; if (ifid_now() !== e) begin errs++; $display("FAIL redir[%0d] ifid got %h exp %h", k, ifid_now(), e); end
         vectors++; if (bus.imemaddr !== s[k].a) begin errs++; $display("FAIL redir[%0d] imemaddr got %h exp %h", k, bus.imemaddr, s[k].a); end
      end
   endtask
   task automatic test_flush_wrap();
      step_t s[5] = '{
         '{1'b1, 32'h7777_7777, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, BUB, 32'h604},
         '{1'b1, 32'h8888_8888, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, '{1'b1, 32'h8888_8888, 32'h604, 32'h608}, 32'h608},
         '{1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 1'b0, 32'h0, BUB, 32'h608},
         '{1'b1, 32'h0,         1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, BUB, 32'hFFFF_FFFC},
         '{1'b1, 32'h9999_9999, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, '{1'b1, 32'h9999_9999, 32'hFFFF_FFFC, 32'h0}, 32'h0}};
      ifid_t e;
      foreach (s[k]) begin
         drive(s[k]); e = exp_q.pop_front();
         vectors++; if (ifid_now() !== e) begin errs++; $display("FAIL flush[%0d] ifid got %h exp %h", k, ifid_now(), e); end
         vectors++; if (bus.imemaddr !== s[k].a) begin errs++; $display("FAIL flush[%0d] imemaddr got %h exp %h", k, bus.imemaddr, s[k].a); end
      end
   endtask
   task automatic test_async_reset();
      step_t s[3] = '{
         '{1'b1, 32'hAAAA_0000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   '{1'b1, 32'hAAAA_0000, 32'h0, 32'h4}, 32'h4},
         '{1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 1'b1, 32'h700, '{1'b1, 32'hAAAA_0000, 32'h0, 32'h4}, 32'h4},
         '{1'b1, 32'hBBBB_0000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   '{1'b1, 32'hBBBB_0000, 32'h100, 32'h104}, 32'h104}};
      ifid_t e;
      foreach (s[k]) begin
         if (k == 2) begin
            idle();
            #2 nrst = 1'b0;
            #1;
            vectors++; if (ifid_now() !== BUB) begin errs++; $display("FAIL arst ifid got %h exp %h", ifid_now(), BUB); end
            vectors++; if (bus.imemaddr !== 32'h100) begin errs++; $display("FAIL arst imemaddr got %h exp 100", bus.imemaddr); end
            #1 nrst = 1'b1;
         end
         drive(s[k]); e = exp_q.pop_front();
         vectors++; if (ifid_now() !== e) begin errs++; $display("FAIL arst[%0d] ifid got %h exp %h", k, ifid_now(), e); end
         vectors++; if (bus.imemaddr !== s[k].a) begin errs++; $display("FAIL arst[%0d] imemaddr got %h exp %h", k, bus.imemaddr, s[k].a); end
      end
   endtask
`ifdef FETCH_HALT_EN
   task automatic test_halt();
      step_t s[3] = '{
         '{1'b1, 32'hFC00_0000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  '{1'b1, 32'hFC00_0000, 32'h104, 32'h108}, 32'h108},
         '{1'b1, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  BUB, 32'h108},
         '{1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b1, 32'h40, BUB, 32'h40}};
      logic hl[3] = '{1'b1, 1'b1, 1'b0};
      ifid_t e;
      foreach (s[k]) begin
         drive(s[k]); e = exp_q.pop_front();
         vectors++; if (ifid_now() !== e) begin errs++; $display("FAIL halt[%0d] ifid got %h exp %h", k, ifid_now(), e); end
         vectors++; if (bus.imemaddr !== s[k].a) begin errs++; $display("FAIL halt[%0d] imemaddr got %h exp %h", k, bus.imemaddr, s[k].a); end
         vectors++; if (bus.fetch_halted !== hl[k]) begin errs++; $display("FAIL halt[%0d] fetch_halted got %b exp %b", k, bus.fetch_halted, hl[k]); end
         vectors++; if (bus.imemREN !== ~hl[k]) begin errs++; $display("FAIL halt[%0d] imemREN got %b exp %b", k, bus.imemREN, ~hl[k]); end
      end
   endtask
`endif
   initial begin
      test_reset();
      test_sequential();
      test_stall();
      test_miss_redirect();
      test_back_to_back_redirect();
      test_flush_wrap();
      test_async_reset();
`ifdef FETCH_HALT_EN
      test_halt();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end
endmodule
